// File: rtl/tv_chk_pkg.sv
// Shared types and helpers for the test-vector response checker.
package tv_chk_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DRAIN, DONE} state_t;

  localparam int unsigned N_W_DEF   = 7;
  localparam int unsigned OUT_W_DEF = 1;
  localparam int unsigned CNT_W_DEF = 8;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/tv_golden_ram.sv
// Golden response table: one synchronous write port, one registered read port, no reset.
module tv_golden_ram #(
  parameter int unsigned N_W   = 7,
  parameter int unsigned OUT_W = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [N_W-1:0]   waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [N_W-1:0]   raddr,
  output logic [OUT_W-1:0] rdata
);

  logic [OUT_W-1:0] mem [2**N_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tv_response_checker.sv
// Checks (pattern, response) observations against the golden table and
// reports mismatch count, first failing pattern, coverage and a pass verdict.
module tv_response_checker
  import tv_chk_pkg::*;
#(
  parameter int unsigned N_W   = N_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             load_en,
  input  logic [N_W-1:0]   load_addr,
  input  logic [OUT_W-1:0] load_data,
  input  logic             check_start,
  input  logic             check_end,
  input  logic             obs_valid,
  output logic             obs_ready,
  input  logic [N_W-1:0]   obs_pattern,
  input  logic [OUT_W-1:0] obs_resp,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cov_count,
  output logic             first_err_valid,
  output logic [N_W-1:0]   first_err_pattern,
  output logic             done,
  output logic             pass
);

  localparam int unsigned     DEPTH   = 2**N_W;
  localparam int unsigned     ERR_MAX = (2**CNT_W) - 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

  state_t           state;
  logic [DEPTH-1:0] seen;
  logic             s1_valid;
  logic [N_W-1:0]   s1_pattern;
  logic [OUT_W-1:0] s1_resp;
  logic [OUT_W-1:0] gold;

  logic             accept;
  logic             new_pat;
  logic             mismatch;
  logic             ram_we;
  logic [CNT_W-1:0] cov_next;
  logic [CNT_W-1:0] err_next;

  always_comb begin
    accept   = obs_valid && obs_ready;
    new_pat  = accept && !seen[obs_pattern];
    cov_next = cov_count + CNT_W'(new_pat);
    mismatch = s1_valid && (gold != s1_resp);
    err_next = mismatch ? CNT_W'(sat_inc(32'(err_count), ERR_MAX)) : err_count;
    ram_we   = load_en && !check_start &&
               ((state == IDLE) || (state == LOAD) || (state == DONE));
  end

  tv_golden_ram #(.N_W(N_W), .OUT_W(OUT_W)) u_ram (
    .clk   (CK),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (obs_pattern),
    .rdata (gold)
  );

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      obs_ready         <= 1'b0;
      seen              <= '0;
      s1_valid          <= 1'b0;
      s1_pattern        <= '0;
      s1_resp           <= '0;
      err_count         <= '0;
      cov_count         <= '0;
      first_err_valid   <= 1'b0;
      first_err_pattern <= '0;
      done              <= 1'b0;
      pass              <= 1'b0;
    end else begin
      s1_valid   <= accept;
      s1_pattern <= obs_pattern;
      s1_resp    <= obs_resp;
      if (mismatch) begin
        err_count <= err_next;
        if (!first_err_valid) begin
          first_err_valid   <= 1'b1;
          first_err_pattern <= s1_pattern;
        end
      end
      if (new_pat) begin
        seen[obs_pattern] <= 1'b1;
        cov_count         <= cov_next;
      end
      case (state)
        IDLE, LOAD, DONE: begin
          if (check_start) begin
            state             <= CHECK;
            obs_ready         <= 1'b1;
            seen              <= '0;
            err_count         <= '0;
            cov_count         <= '0;
            first_err_valid   <= 1'b0;
            first_err_pattern <= '0;
            done              <= 1'b0;
            pass              <= 1'b0;
          end else if (load_en) begin
            state <= LOAD;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        CHECK: begin
          // Leave on the accept that completes coverage, not a cycle later.
          if (check_end || (cov_next == FULL)) begin
            state     <= DRAIN;
            obs_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // The last in-flight compare resolves on this edge, so use err_next.
          state <= DONE;
          done  <= 1'b1;
          pass  <= (err_next == '0) && (cov_count == FULL);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tv_response_checker.md
# tv_response_checker

Hardware response checker for exhaustive test-vector runs on benchmark circuits: the receiving end of the pattern/response stream a vector driver produces. It holds a golden response table indexed by input pattern and accepts (pattern, observed response) pairs over a valid/ready handshake. For each run it reports the mismatch count, the first failing pattern, pattern coverage, and a final pass/fail verdict. It sits between the DUT output capture and the result-logging path of the trojan-detection flow.

## Interface
- N_W, 7, input pattern width; the table holds 2^N_W entries
- OUT_W, 1, DUT response width
- CNT_W, 8, width of the error and coverage counters; must satisfy CNT_W >= N_W+1
- CK  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- load_en  input  1  write golden entry this cycle
- load_addr  input  N_W  golden entry index (pattern)
- load_data  input  OUT_W  expected response for load_addr
- check_start  input  1  begin a check run
- check_end  input  1  force end of run before full coverage
- obs_valid  input  1  observation present
- obs_ready  output  1  checker accepts observation
- obs_pattern  input  N_W  applied pattern
- obs_resp  input  OUT_W  observed DUT response
- err_count  output  CNT_W  mismatches this run; saturating
- cov_count  output  CNT_W  distinct patterns seen this run
- first_err_valid  output  1  at least one mismatch this run
- first_err_pattern  output  N_W  pattern of the first mismatch
- done  output  1  run finished, held until next run
- pass  output  1  valid when done: err_count==0 and cov_count==2^N_W

## Operation
- FSM states:
  - IDLE: reset state.
  - LOAD: load_en in IDLE or DONE moves here.
  - CHECK: check_start in IDLE, LOAD or DONE moves here.
  - DRAIN: entered from CHECK on full coverage or check_end.
  - DONE: entered from DRAIN once the pipeline is empty.
- load_en is honoured only in IDLE, LOAD and DONE; it is ignored in CHECK and DRAIN.
  - load_en in DONE clears done and pass.
  - If check_start and load_en are asserted together, check_start wins and the write is dropped.
- On entry to CHECK, the following clear in the entry cycle: err_count, cov_count, first_err_valid, first_err_pattern, done, pass, and the 2^N_W-bit coverage bitmap.
- obs_ready is 1 only in CHECK. An observation is accepted when obs_valid && obs_ready.
- Per accepted observation:
  - Golden table read at obs_pattern, then comparison of all OUT_W bits.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch, first_err_pattern latches and first_err_valid sets.
- Coverage:
  - An unseen pattern sets its bitmap bit and increments cov_count.
  - A duplicate pattern is still compared and counted in err_count; coverage is unchanged.
- Run end: cov_count reaching 2^N_W, or check_end in CHECK, moves to DRAIN.
  - An observation accepted in the same cycle as check_end is fully processed.
- The golden table has no reset. Its contents survive reset and repeated runs.
- Reset mid-run returns to IDLE with all outputs at their reset values and in-flight comparisons discarded.

## Timing
- Reset values of all outputs: obs_ready=0, err_count=0, cov_count=0, first_err_valid=0, first_err_pattern=0, done=0, pass=0.
- Load: a write at cycle t is readable by an observation accepted at t+1 or later.
- Observation accepted at t:
  - cov_count is updated at t+1 (registered table read).
  - The comparison resolves at t+2: err_count and first_err update, visible at t+2.
- Full throughput: one observation per cycle; back-to-back accepts are supported.
- End condition reached at t (final accept or check_end):
  - obs_ready=0 from t+1.
  - DRAIN at t+1.
  - done=1 and final pass at t+2; all counters are final in the same cycle as done.
- check_start in DONE: done drops the next cycle and a new run begins.

## Structure
- Shared package tv_chk_pkg holds:
  - state enum {IDLE, LOAD, CHECK, DRAIN, DONE};
  - default N_W, OUT_W and CNT_W localparams;
  - a saturating-increment function.
- One sub-module: tv_golden_ram, a 2^N_W x OUT_W RAM with one synchronous write port, one registered read port, and no reset.
- Top level holds the FSM, coverage bitmap, two-stage compare pipeline and counters.

## Test plan
- Load table as parity(pattern) with N_W=7 and OUT_W=1, then stream patterns 0..127 with matching responses -> done at last accept+2, err_count=0, cov_count=128, pass=1.
- Same load, with obs_resp inverted for patterns 5 and 90 -> err_count=2, first_err_pattern=5, pass=0.
- Stream patterns 0..63 twice, then assert check_end -> cov_count=64, err_count=0, pass=0, done exactly 2 cycles after check_end.
- Wrong response on all 128 patterns plus 200 repeats, with CNT_W=8 -> err_count saturates at 255.
- Drop reset low during CHECK after 30 accepts -> all outputs 0 immediately, IDLE; a rerun without reload gives pass=1 (table retained).
- Assert load_en in CHECK with a conflicting value, and obs_valid toggled randomly -> table unchanged, no observation lost or duplicated, pass=1.
